// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: driver register map and
// the feeder's state encoding.
package seg7_pkg;

  localparam logic [1:0] SEG7_ADDR_DATA = 2'd0;
  localparam logic [1:0] SEG7_ADDR_ON   = 2'd1;
  localparam logic [1:0] SEG7_ADDR_DP   = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StWrData,
    StWrOn,
    StWrDp
  } feeder_state_e;

endpackage

// File: rtl/seg7_bcd_feeder_if.sv
// Value input handshake plus the driver's write-only control port and overflow flag.
interface seg7_bcd_feeder_if #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned BIN_WIDTH = 14
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_WIDTH-1:0] in_data;
  logic [DIGITS-1:0]    in_dp;
  logic [1:0]           ctrl_address;
  logic                 ctrl_write;
  logic [31:0]          ctrl_writedata;
  logic                 ovf;

  // master: the feeder, which masters the driver control port
  modport master (
    input  in_valid, in_data, in_dp,
    output in_ready, ctrl_address, ctrl_write, ctrl_writedata, ovf
  );

  modport slave (
    output in_valid, in_data, in_dp,
    input  in_ready, ctrl_address, ctrl_write, ctrl_writedata, ovf
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble, applied before each left shift.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);
  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
endmodule

// File: rtl/seg7_bcd_feeder.sv
// Serial binary-to-BCD converter that programs the static 7-segment driver with
// data, digit-enable and decimal-point writes after each conversion.
module seg7_bcd_feeder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BIN_WIDTH   = 14,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  seg7_bcd_feeder_if.master bus
);

  localparam int unsigned BcdW = DIGITS * 4;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_bcd_feeder: DIGITS must be in 1..8");
  end
  if (BIN_WIDTH < 1 || BIN_WIDTH > 32) begin : g_bad_width
    $error("seg7_bcd_feeder: BIN_WIDTH must be in 1..32");
  end

  feeder_state_e        state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BcdW-1:0]      bcd_q;
  logic [DIGITS-1:0]    dp_q;
  logic                 ovf_flag_q;
  logic [5:0]           cnt_q;
  logic [1:0]           ctrl_address_q;
  logic                 ctrl_write_q;
  logic [31:0]          ctrl_writedata_q;
  logic                 ovf_q;

  logic [BcdW-1:0]      bcd_adj;
  logic [BcdW-1:0]      bcd_shift;
  logic [BIN_WIDTH-1:0] bin_shift;
  logic                 carry_out;
  logic                 ovf_next;
  logic [BcdW-1:0]      bcd_sat;
  logic [DIGITS-1:0]    on_mask;
  logic                 seen_nonzero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  assign {carry_out, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};
  assign ovf_next = ovf_flag_q | carry_out;
  assign bcd_sat  = ovf_next ? {DIGITS{4'h9}} : bcd_shift;

  // bcd_q holds the saturated value once WR_DATA is reached
  always_comb begin
    on_mask      = '0;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nonzero = seen_nonzero | (bcd_q[4*i +: 4] != 4'd0);
      on_mask[i]   = seen_nonzero | (i == 0) | ~BLANK_ZEROS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      bin_q            <= '0;
      bcd_q            <= '0;
      dp_q             <= '0;
      ovf_flag_q       <= 1'b0;
      cnt_q            <= '0;
      ctrl_address_q   <= SEG7_ADDR_DATA;
      ctrl_write_q     <= 1'b0;
      ctrl_writedata_q <= '0;
      ovf_q            <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ctrl_write_q <= 1'b0;
          if (bus.in_valid) begin
            bin_q      <= bus.in_data;
            dp_q       <= bus.in_dp;
            bcd_q      <= '0;
            ovf_flag_q <= 1'b0;
            cnt_q      <= 6'(BIN_WIDTH);
            state_q    <= StConv;
          end
        end
        StConv: begin
          bin_q      <= bin_shift;
          bcd_q      <= bcd_shift;
          ovf_flag_q <= ovf_next;
          cnt_q      <= cnt_q - 6'd1;
          // Last bit: issue the data write on this edge so it lands in WR_DATA
          if (cnt_q == 6'd1) begin
            bcd_q            <= bcd_sat;
            ctrl_write_q     <= 1'b1;
            ctrl_address_q   <= SEG7_ADDR_DATA;
            ctrl_writedata_q <= 32'(bcd_sat);
            ovf_q            <= ovf_next;
            state_q          <= StWrData;
          end
        end
        StWrData: begin
          ctrl_address_q   <= SEG7_ADDR_ON;
          ctrl_writedata_q <= 32'(on_mask);
          state_q          <= StWrOn;
        end
        StWrOn: begin
          ctrl_address_q   <= SEG7_ADDR_DP;
          ctrl_writedata_q <= 32'(dp_q);
          state_q          <= StWrDp;
        end
        StWrDp: begin
          ctrl_write_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready       = (state_q == StIdle);
  assign bus.ctrl_address   = ctrl_address_q;
  assign bus.ctrl_write     = ctrl_write_q;
  assign bus.ctrl_writedata = ctrl_writedata_q;
  assign bus.ovf            = ovf_q;

endmodule

// File: tb/tb_seg7_bcd_feeder.sv
// Bench for seg7_bcd_feeder: directed vector table, random values against a
// decimal-arithmetic model, plus back-to-back and mid-operation reset sequences.
module tb_seg7_bcd_feeder;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned BW     = 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg7_bcd_feeder_if #(.DIGITS(DIGITS), .BIN_WIDTH(BW)) bus ();
  seg7_bcd_feeder_if #(.DIGITS(DIGITS), .BIN_WIDTH(BW)) bus_nb ();

  assign bus_nb.in_valid = bus.in_valid;
  assign bus_nb.in_data  = bus.in_data;
  assign bus_nb.in_dp    = bus.in_dp;

  seg7_bcd_feeder #(.DIGITS(DIGITS), .BIN_WIDTH(BW), .BLANK_ZEROS(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  seg7_bcd_feeder #(.DIGITS(DIGITS), .BIN_WIDTH(BW), .BLANK_ZEROS(1'b0)) dut_nb (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nb)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [BW-1:0]     v;
    logic [DIGITS-1:0] dp;
    logic [31:0]       exp_data;
    logic [31:0]       exp_on;
    bit                exp_ovf;
  } vec_t;

  wr_t wq[$];
  wr_t wq_nb[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ctrl_write) wq.push_back('{cyc, bus.ctrl_address, bus.ctrl_writedata});
    if (bus_nb.ctrl_write) wq_nb.push_back('{cyc, bus_nb.ctrl_address, bus_nb.ctrl_writedata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal model: saturate, split into digits, enable up to the top nonzero digit.
  task automatic model(input int unsigned v, output logic [31:0] d, output logic [31:0] on,
                       output bit o);
    int unsigned lim = 1;
    int unsigned p = 1;
    int top = 0;
    for (int i = 0; i < int'(DIGITS); i++) lim *= 10;
    o = (v >= lim);
    if (o) v = lim - 1;
    d = 0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      int unsigned dig = (v / p) % 10;
      d |= dig << (4 * i);
      if (dig != 0) top = i;
      p *= 10;
    end
    on = (32'd1 << (top + 1)) - 1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle before send"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, " ctrl_write"}, 32'(bus.ctrl_write), 32'd0);
    chk({tag, " ctrl_address"}, 32'(bus.ctrl_address), 32'd0);
    chk({tag, " ctrl_writedata"}, bus.ctrl_writedata, 32'd0);
    chk({tag, " ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic txn(input logic [BW-1:0] v, input logic [DIGITS-1:0] dp,
                     input logic [31:0] ed, input logic [31:0] eon, input bit eovf,
                     input string tag);
    int a;
    int n;
    logic [31:0] exp_w[3];
    logic [31:0] exp_nb[3];
    @(negedge clk);
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_dp    = dp;
    a = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = BW'($urandom);
    bus.in_dp    = DIGITS'($urandom);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(BW + 3));
    exp_w  = '{ed, eon, 32'(dp)};
    exp_nb = '{ed, 32'hF, 32'(dp)};
    chk({tag, " write count"}, 32'(wq.size()), 32'd3);
    chk({tag, " write count nb"}, 32'(wq_nb.size()), 32'd3);
    if (wq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s w%0d addr", tag, i), 32'(wq[i].addr), 32'(i));
        chk($sformatf("%s w%0d data", tag, i), wq[i].data, exp_w[i]);
        chk($sformatf("%s w%0d cycle", tag, i), 32'(wq[i].cyc - a), 32'(BW + i));
      end
    end
    if (wq_nb.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("%s nb w%0d data", tag, i), wq_nb[i].data, exp_nb[i]);
    end
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(eovf));
    chk({tag, " ovf nb"}, 32'(bus_nb.ovf), 32'(eovf));
    wq.delete();
    wq_nb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int a;
    int n;
    logic [31:0] md;
    logic [31:0] mon;
    bit mo;
    logic [31:0] exp6[6];
    int ecyc[6];

    vecs[0] = '{14'd1234,  4'b0010, 32'h1234, 32'hF, 1'b0};
    vecs[1] = '{14'd7,     4'b0000, 32'h0007, 32'h1, 1'b0};
    vecs[2] = '{14'd0,     4'b0001, 32'h0000, 32'h1, 1'b0};
    vecs[3] = '{14'd10000, 4'b0100, 32'h9999, 32'hF, 1'b1};
    vecs[4] = '{14'd16383, 4'b1111, 32'h9999, 32'hF, 1'b1};
    vecs[5] = '{14'd42,    4'b1000, 32'h0042, 32'h3, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dp    = '0;
    repeat (2) @(negedge clk);
    check_outputs_reset("reset");
    reset_n = 1'b1;

    foreach (vecs[k])
      txn(vecs[k].v, vecs[k].dp, vecs[k].exp_data, vecs[k].exp_on, vecs[k].exp_ovf,
          $sformatf("vec%0d", k));

    for (int k = 0; k < 20; k++) begin
      logic [BW-1:0] v = BW'($urandom_range(0, 16383));
      logic [DIGITS-1:0] dp = DIGITS'($urandom);
      if (k % 4 == 0) v = BW'($urandom_range(0, 99));
      model(v, md, mon, mo);
      txn(v, dp, md, mon, mo, $sformatf("rnd%0d", k));
    end

    // Back-to-back with in_valid held: 9999 then 1; in_data changes during conversion
    @(negedge clk);
    wait_ready("b2b");
    bus.in_valid = 1'b1;
    bus.in_data  = 14'd9999;
    bus.in_dp    = 4'b1000;
    a = cyc + 1;
    @(negedge clk);
    bus.in_data = 14'd1;
    bus.in_dp   = 4'b0001;
    while (cyc < a + 17) @(negedge clk);
    chk("b2b ready at cycle 18", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("b2b second accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    exp6 = '{32'h9999, 32'hF, 32'h8, 32'h0001, 32'h1, 32'h1};
    ecyc = '{14, 15, 16, 32, 33, 34};
    chk("b2b write count", 32'(wq.size()), 32'd6);
    if (wq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("b2b w%0d addr", i), 32'(wq[i].addr), 32'(i % 3));
        chk($sformatf("b2b w%0d data", i), wq[i].data, exp6[i]);
        chk($sformatf("b2b w%0d cycle", i), 32'(wq[i].cyc - a), 32'(ecyc[i]));
      end
    end
    chk("b2b ovf", 32'(bus.ovf), 32'd0);
    wq.delete();
    wq_nb.delete();

    // Reset during CONV cycle 5, with ovf previously set
    txn(14'd16383, 4'b0000, 32'h9999, 32'hF, 1'b1, "preovf");
    @(negedge clk);
    wait_ready("rst1");
    bus.in_valid = 1'b1;
    bus.in_data  = 14'd1234;
    a = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (cyc < a + 4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_outputs_reset("rst1 during");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst1 ready after release", 32'(bus.in_ready), 32'd1);
    repeat (25) @(negedge clk);
    chk("rst1 no writes", 32'(wq.size()), 32'd0);
    wq.delete();
    wq_nb.delete();

    // Reset between WR_DATA and WR_ON
    wait_ready("rst2");
    bus.in_valid = 1'b1;
    bus.in_data  = 14'd5678;
    a = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (cyc < a + 14) @(negedge clk);
    chk("rst2 data write visible", 32'(bus.ctrl_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_reset("rst2 during");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst2 ready after release", 32'(bus.in_ready), 32'd1);
    repeat (25) @(negedge clk);
    chk("rst2 only data write", 32'(wq.size()), 32'd1);
    if (wq.size() >= 1) chk("rst2 data value", wq[0].data, 32'h5678);
    wq.delete();
    wq_nb.delete();

    txn(14'd305, 4'b0011, 32'h0305, 32'h7, 1'b0, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
